responder_arbiter: RTL and testbench

Four-contestant quiz arbiter that consumes the one-cycle, active-high press pulses from the key debounce stage. It arms on a host start pulse and latches the first contestant to press. It then runs a per-second answer countdown and drives the winner LEDs and a buzzer. It sits between the key filter outputs and the board LED, seven-segment and buzzer drivers.

---
 rtl/responder_arbiter.sv | 114 +++++++++++
 tb/tb_responder_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/responder_arbiter.sv
// Four-contestant quiz arbiter: arm, first-press latch, countdown, buzzer.
// Optional FALSE_START_EN: presses while idle set sticky foul flags that mask winning.
module responder_arbiter #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int ANSWER_SEC  = 10,
  parameter int BEEP_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] press,
  input  logic       start,
  input  logic       clear,
  output logic [1:0] state,
  output logic [3:0] winner,
  output logic [3:0] sec_left,
  output logic       buzzer,
  output logic [3:0] foul
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } st_t;

  st_t           st;
  logic [PW-1:0] presc;
  logic [BW-1:0] beep;
  logic [3:0]    eligible;
  logic [3:0]    first;
  logic          tick;

`ifdef FALSE_START_EN
  logic [3:0] foul_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foul_q <= '0;
    end else if (clear) begin
      foul_q <= '0;
    end else if (st == IDLE) begin
      foul_q <= foul_q | press;
    end
  end

  assign foul     = foul_q;
  assign eligible = press & ~foul_q;
`else
  assign foul     = 4'b0000;
  assign eligible = press;
`endif

  // isolate the lowest set bit so ties go to the lowest index
  assign first  = eligible & (~eligible + 4'd1);
  assign tick   = (presc == PW'(CLK_FREQ - 1));
  assign state  = st;
  assign buzzer = (beep != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      winner   <= '0;
      sec_left <= '0;
      presc    <= '0;
      beep     <= '0;
    end else if (clear) begin
      st       <= IDLE;
      winner   <= '0;
      sec_left <= '0;
      presc    <= '0;
      beep     <= '0;
    end else begin
      if (beep != '0) begin
        beep <= beep - BW'(1);
      end
      unique case (st)
        IDLE: begin
          presc <= '0;
          if (start) begin
            st       <= ARMED;
            sec_left <= 4'(ANSWER_SEC);
          end
        end
        ARMED: begin
          if (eligible != 4'b0000) begin
            st     <= LOCKED;
            winner <= first;
            presc  <= '0;
            beep   <= BW'(BEEP_CYCLES);
          end else if (tick) begin
            presc <= '0;
            if (sec_left == 4'd1) begin
              st       <= TIMEOUT;
              sec_left <= 4'd0;
              beep     <= BW'(BEEP_CYCLES);
            end else begin
              sec_left <= sec_left - 4'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: begin
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed bench for responder_arbiter with CLK_FREQ=10, ANSWER_SEC=3, BEEP_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_responder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] press;
  logic       start;
  logic       clear;
  logic [1:0] state;
  logic [3:0] winner;
  logic [3:0] sec_left;
  logic       buzzer;
  logic [3:0] foul;

  int checks;
  int errors;

  responder_arbiter #(
    .CLK_FREQ   (10),
    .ANSWER_SEC (3),
    .BEEP_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .press   (press),
    .start   (start),
    .clear   (clear),
    .state   (state),
    .winner  (winner),
    .sec_left(sec_left),
    .buzzer  (buzzer),
    .foul    (foul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic do_press(input logic [3:0] p);
    press = p;
    cyc(1);
    press = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    press  = 4'b0000;
    start  = 1'b0;
    clear  = 1'b0;
    rst_n  = 1'b0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_winner", winner, 0);
    chk("rst_sec", sec_left, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_foul", foul, 0);
    rst_n = 1'b1;
    cyc(1);

    // basic win
    do_start();
    chk("arm_state", state, 1);
    chk("arm_sec", sec_left, 3);
    cyc(4);
    do_press(4'b0100);
    chk("win_state", state, 2);
    chk("win_winner", winner, 4'b0100);
    chk("win_sec", sec_left, 3);
    chk("win_buz0", buzzer, 1);
    cyc(3);
    chk("win_buz3", buzzer, 1);
    cyc(1);
    chk("win_buz4", buzzer, 0);
    do_press(4'b0001);
    chk("lock_winner", winner, 4'b0100);
    chk("lock_state", state, 2);
    do_start();
    chk("lock_start", state, 2);
    do_clear();
    chk("clr_state", state, 0);
    chk("clr_winner", winner, 0);
    chk("clr_sec", sec_left, 0);

    // simultaneous press, then clear while buzzing
    do_start();
    cyc(2);
    do_press(4'b1001);
    chk("sim_winner", winner, 4'b0001);
    chk("sim_state", state, 2);
    chk("sim_buz", buzzer, 1);
    do_clear();
    chk("clrbuz_buz", buzzer, 0);
    chk("clrbuz_state", state, 0);

    // timeout
    do_start();
    cyc(9);
    chk("to_sec9", sec_left, 3);
    cyc(1);
    chk("to_sec10", sec_left, 2);
    cyc(10);
    chk("to_sec20", sec_left, 1);
    cyc(9);
    chk("to_st29", state, 1);
    cyc(1);
    chk("to_st30", state, 3);
    chk("to_sec30", sec_left, 0);
    chk("to_winner", winner, 0);
    chk("to_buz0", buzzer, 1);
    cyc(3);
    chk("to_buz3", buzzer, 1);
    cyc(1);
    chk("to_buz4", buzzer, 0);
    do_press(4'b0010);
    chk("to_press", state, 3);
    chk("to_press_w", winner, 0);
    do_clear();

    // final-tick race
    do_start();
    cyc(29);
    chk("race_pre", sec_left, 1);
    do_press(4'b0010);
    chk("race_state", state, 2);
    chk("race_sec", sec_left, 1);
    chk("race_winner", winner, 4'b0010);
    do_press(4'b0001);
    chk("race_lock", winner, 4'b0010);
    do_clear();

    // clear beats start
    start = 1'b1;
    clear = 1'b1;
    cyc(1);
    start = 1'b0;
    clear = 1'b0;
    chk("prio_state", state, 0);
    chk("prio_sec", sec_left, 0);

    // asynchronous reset mid-countdown
    do_start();
    cyc(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_sec", sec_left, 3'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

`ifdef FALSE_START_EN
    do_press(4'b0001);
    chk("fs_foul", foul, 4'b0001);
    chk("fs_state", state, 0);
    do_start();
    do_press(4'b0011);
    chk("fs_winner", winner, 4'b0010);
    chk("fs_foul_hold", foul, 4'b0001);
    do_clear();
    chk("fs_clr", foul, 0);
    do_press(4'b1111);
    chk("fs_all", foul, 4'b1111);
    do_start();
    do_press(4'b1111);
    chk("fs_all_st", state, 1);
    do_clear();
`else
    do_press(4'b0001);
    chk("nf_foul", foul, 0);
    chk("nf_state", state, 0);
    do_start();
    do_press(4'b0011);
    chk("nf_winner", winner, 4'b0001);
    do_clear();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
